// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } arb_state_e;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    localparam int unsigned RAM_AW = 22;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester buses plus RAM-side signals of the arbiter.
// master: requesters and RAM instance; slave: the arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              p0_valid;
    logic [31:0]       p0_addr;
    logic [31:0]       p0_wdata;
    logic [3:0]        p0_wstrb;
    logic              p0_ready;
    logic [31:0]       p0_rdata;

    logic              p1_valid;
    logic [31:0]       p1_addr;
    logic [31:0]       p1_wdata;
    logic [3:0]        p1_wstrb;
    logic              p1_ready;
    logic [31:0]       p1_rdata;

    logic [3:0]        ram_wen;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output p0_valid, p0_addr, p0_wdata, p0_wstrb,
        output p1_valid, p1_addr, p1_wdata, p1_wstrb,
        output ram_rdata,
        input  p0_ready, p0_rdata, p1_ready, p1_rdata,
        input  ram_wen, ram_addr, ram_wdata
    );

    modport slave (
        input  p0_valid, p0_addr, p0_wdata, p0_wstrb,
        input  p1_valid, p1_addr, p1_wdata, p1_wstrb,
        input  ram_rdata,
        output p0_ready, p0_rdata, p1_ready, p1_rdata,
        output ram_wen, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational grant selection between the two requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise port 0 has priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic last_served,
    output logic grant
);

    always_comb begin
        grant = ARB_P0;
        if (p1_valid && !p0_valid) begin
            grant = ARB_P1;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (p0_valid && p1_valid && last_served == ARB_P0) begin
            grant = ARB_P1;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two valid/ready requesters onto a single-port synchronous-read RAM.
// Build with ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned WORDS = 256
) (
    input  logic          clk,
    input  logic          resetn,
    ram_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              gnt_q;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              inr_q;
    logic [31:0]       rdata0_q, rdata1_q;

    logic              pick_gnt;
    logic              last_served;
    logic              take;
    logic [RAM_AW-1:0] req_word;
    logic              req_inr;
    logic              resp;
    logic [31:0]       resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= ARB_P1;
        end else if (take) begin
            last_q <= pick_gnt;
        end
    end

    assign last_served = last_q;
`else
    assign last_served = ARB_P1;
`endif

    ram_arb_pick u_pick (
        .p0_valid    (bus.p0_valid),
        .p1_valid    (bus.p1_valid),
        .last_served (last_served),
        .grant       (pick_gnt)
    );

    assign take     = (state_q == StIdle) && (bus.p0_valid || bus.p1_valid);
    assign req_word = (pick_gnt == ARB_P1) ? bus.p1_addr[RAM_AW+1:2] : bus.p0_addr[RAM_AW+1:2];
    assign req_inr  = 32'(req_word) < WORDS;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            gnt_q    <= ARB_P0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            inr_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                gnt_q   <= pick_gnt;
                addr_q  <= req_word;
                wdata_q <= (pick_gnt == ARB_P1) ? bus.p1_wdata : bus.p0_wdata;
                wstrb_q <= (pick_gnt == ARB_P1) ? bus.p1_wstrb : bus.p0_wstrb;
                inr_q   <= req_inr;
            end
            if (bus.p0_ready) rdata0_q <= resp_data;
            if (bus.p1_ready) rdata1_q <= resp_data;
        end
    end

    // Ready is masked while reset is held so an aborted access never completes.
    assign resp      = (state_q == StResp) && resetn;
    assign resp_data = inr_q ? bus.ram_rdata : 32'h0;

    assign bus.p0_ready  = resp && (gnt_q == ARB_P0);
    assign bus.p1_ready  = resp && (gnt_q == ARB_P1);
    assign bus.p0_rdata  = bus.p0_ready ? resp_data : rdata0_q;
    assign bus.p1_rdata  = bus.p1_ready ? resp_data : rdata1_q;

    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wen   = (state_q == StIssue && inr_q) ? wstrb_q : 4'h0;

    logic unused_addr;
    assign unused_addr = ^{bus.p0_addr[31:RAM_AW+2], bus.p0_addr[1:0],
                           bus.p1_addr[31:RAM_AW+2], bus.p1_addr[1:0]};

endmodule
